soc_it_message_recv_arbiter: RTL and testbench
==============================================

SOC_IT_MESSAGE_RECV_ARBITER -- requirements
Module: soc_it_message_recv_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of message source channels (1..8).
REQ-002 Parameter DATA_W, default 128, payload width in bits.
REQ-003 Parameter DEPTH, default 16, per-channel FIFO depth in beats; power of two, at least 2.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 ch_valid  in  NUM_CH  per-channel beat valid.
REQ-007 ch_ready  out  NUM_CH  per-channel beat accept; equals FIFO not full.
REQ-008 ch_last  in  NUM_CH  per-channel final beat of message.
REQ-009 ch_data  in  NUM_CH*DATA_W  flattened beats; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-010 recv_msg_request  out  1  asks downstream for message slot.
REQ-011 recv_msg_ack  in  1  downstream grants slot.
REQ-012 recv_msg_src_rdy  out  1  payload beat valid.
REQ-013 recv_msg_dst_rdy  in  1  downstream accepts beat.
REQ-014 recv_msg_payload  out  DATA_W  beat data.
REQ-015 recv_msg_last  out  1  current beat ends message.
REQ-016 recv_msg_chan  out  $clog2(NUM_CH) (min 1)  source channel of current message.
REQ-017 err_oversize  out  NUM_CH  sticky: channel FIFO full with no complete message stored.

Function
REQ-018 Channel write occurs when ch_valid[i] && ch_ready[i]; stores {ch_last, ch_data} in FIFO i.
REQ-019 msg_cnt[i] counts complete messages in FIFO i; it increments on a write with last and decrements on a transfer of the last beat from channel i; on the same cycle it stays unchanged.
REQ-020 States: IDLE, REQ, XFER.
REQ-021 IDLE: if any msg_cnt != 0, grant is the round-robin winner, searching from last_grant+1 modulo NUM_CH; grant is latched and the FSM moves to REQ.
REQ-022 REQ: recv_msg_request = 1, registered, first high the cycle after the grant; on recv_msg_ack = 1 go to XFER, so request is low the following cycle.
REQ-023 recv_msg_ack outside REQ is ignored.
REQ-024 XFER: recv_msg_src_rdy = FIFO[grant] not empty; payload and last come from the FIFO head (first-word fall-through); recv_msg_chan = grant.
REQ-025 A beat transfers and pops when src_rdy && dst_rdy; on a last-beat transfer, last_grant = grant and the FSM returns to IDLE.
REQ-026 Minimum gap: one IDLE cycle between messages; back-to-back beats within a message run at 1 beat/cycle.
REQ-027 When src_rdy = 0, recv_msg_payload = 0, recv_msg_last = 0 and recv_msg_chan = 0.
REQ-028 A channel may write while it is being drained; a simultaneous push and pop keeps occupancy constant.
REQ-029 FIFO i full with msg_cnt[i] == 0 sets err_oversize[i]; messages longer than DEPTH are unsupported, and ch_ready[i] stays low.
REQ-030 Pointer and counter wrap-around is modulo DEPTH with no lost beats.

Reset
REQ-031 rst low at any time asynchronously clears: FSM to IDLE, last_grant = NUM_CH-1 (so channel 0 wins first), FIFOs emptied, msg_cnt = 0, err_oversize = 0, request = 0, src_rdy = 0.
REQ-032 Reset mid-message discards the in-flight message; no partial beats are emitted after release.
REQ-033 ch_ready is 0 during reset and 1 in the first cycle after release.

Structure
REQ-034 Package soc_it_msg_pkg holds the state enum (IDLE/REQ/XFER) and the default DATA_W/DEPTH/NUM_CH constants.
REQ-035 Sub-module soc_it_msg_fifo: synchronous first-word fall-through FIFO with full, empty and count; one instance per channel, generated in a loop.

Verification
REQ-036 After reset, push a 3-beat message on channel 2 with data 0xA,0xB,0xC and ack 2 cycles after request, dst_rdy=1 -> payload A,B,C on consecutive cycles, last on C, chan=2.
REQ-037 Complete messages waiting on channels 0, 1 and 3 -> grant order 0,1,3, then after a new message on channel 0 -> order continues 0.
REQ-038 In XFER, toggle dst_rdy 1,0,1,0 on a 4-beat message -> payload holds during the low cycles, 4 transfers total, no duplicates.
REQ-039 Push 16 beats without last on channel 1 (DEPTH=16) -> ch_ready[1]=0, err_oversize[1]=1, other channels still served.
REQ-040 Assert rst low during beat 2 of 5 -> outputs are 0 immediately, FIFOs empty after release, no stale beats emitted.
REQ-041 Assert recv_msg_ack while in IDLE -> no state change, request stays 0.

Source files
------------

// File: rtl/soc_it_msg_pkg.sv
// Shared types and default sizing for the message receive arbiter.
// Holds the arbiter FSM state encoding and default parameter values.
package soc_it_msg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 128;
    localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/soc_it_msg_fifo.sv
// First-word fall-through FIFO, one per message source channel.
// Ports: i_push/i_din write, i_pop/o_dout read head, o_full/o_empty/o_count status.
module soc_it_msg_fifo #(
    parameter int W     = 129,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty,
    output logic [AW:0]  o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/soc_it_message_recv_arbiter.sv
// Buffers per-channel messages and forwards whole messages downstream, round-robin.
// Ports: ch_* per-channel beat inputs, recv_msg_* downstream handshake, err_oversize sticky.
module soc_it_message_recv_arbiter
    import soc_it_msg_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH-1:0]        ch_last,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     recv_msg_request,
    input  logic                     recv_msg_ack,
    output logic                     recv_msg_src_rdy,
    input  logic                     recv_msg_dst_rdy,
    output logic [DATA_W-1:0]        recv_msg_payload,
    output logic                     recv_msg_last,
    output logic [CW-1:0]            recv_msg_chan,
    output logic [NUM_CH-1:0]        err_oversize
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_grant;
    logic [CW-1:0]   w_grant_nxt;
    logic [CW-1:0]   r_last_grant;
    logic [CW-1:0]   w_last_nxt;
    logic [CW-1:0]   w_winner;
    logic            w_found;
    int              w_idx;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_has_msg;
    logic [DATA_W:0] w_head [NUM_CH];
    logic [DATA_W:0] w_head_sel;
    logic            w_src;
    logic            w_fire;

    assign w_head_sel = w_head[r_grant];
    assign w_src      = (r_state == XFER) & ~w_empty[r_grant];
    assign w_fire     = w_src & recv_msg_dst_rdy;

    assign recv_msg_request = (r_state == REQ);
    assign recv_msg_src_rdy = w_src;
    assign recv_msg_payload = w_src ? w_head_sel[DATA_W-1:0] : '0;
    assign recv_msg_last    = w_src & w_head_sel[DATA_W];
    assign recv_msg_chan    = w_src ? r_grant : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [AW:0] r_msg_cnt;
        logic        r_err;
        logic [AW:0] w_cnt;
        logic        w_inc;
        logic        w_dec;

        // Ready is forced low while reset is held.
        assign ch_ready[i]     = rst & ~w_full[i];
        assign w_wr[i]         = ch_valid[i] & ch_ready[i];
        assign w_pop[i]        = w_fire & (r_grant == CW'(i));
        assign w_inc           = w_wr[i] & ch_last[i];
        assign w_dec           = w_pop[i] & w_head[i][DATA_W];
        assign w_has_msg[i]    = (r_msg_cnt != '0);
        assign err_oversize[i] = r_err;

        soc_it_msg_fifo #(
            .W     (DATA_W + 1),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_wr[i]),
            .i_din   ({ch_last[i], ch_data[i*DATA_W +: DATA_W]}),
            .i_pop   (w_pop[i]),
            .o_dout  (w_head[i]),
            .o_full  (w_full[i]),
            .o_empty (w_empty[i]),
            .o_count (w_cnt)
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_msg_cnt <= '0;
                r_err     <= 1'b0;
            end else begin
                if (w_inc && !w_dec)      r_msg_cnt <= r_msg_cnt + 1'b1;
                else if (w_dec && !w_inc) r_msg_cnt <= r_msg_cnt - 1'b1;
                // Full with no terminator stored: this message can never drain.
                if (w_cnt == (AW+1)'(DEPTH) && r_msg_cnt == '0)
                    r_err <= 1'b1;
            end
        end
    end

    // Round-robin search starting just after the last served channel.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = (int'(r_last_grant) + k) % NUM_CH;
            if (!w_found && w_has_msg[w_idx]) begin
                w_found  = 1'b1;
                w_winner = CW'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_winner;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (recv_msg_ack) w_state_nxt = XFER;
            end
            XFER: begin
                if (w_fire && w_head_sel[DATA_W]) begin
                    w_last_nxt  = r_grant;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= CW'(NUM_CH - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_soc_it_message_recv_arbiter.sv
// Scoreboard bench for the message receive arbiter.
// Drives channel beats, models the downstream, compares received beats.
module tb_soc_it_message_recv_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 128;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [1:0]    c;
        int            cyc;
    } beat_t;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    ch_valid;
    logic [NCH-1:0]    ch_ready;
    logic [NCH-1:0]    ch_last;
    logic [NCH*DW-1:0] ch_data;
    logic              recv_msg_request;
    logic              recv_msg_ack;
    logic              recv_msg_src_rdy;
    logic              recv_msg_dst_rdy;
    logic [DW-1:0]     recv_msg_payload;
    logic              recv_msg_last;
    logic [1:0]        recv_msg_chan;
    logic [NCH-1:0]    err_oversize;

    beat_t exp_q[$];
    beat_t rx_q[$];

    int n_cmp;
    int n_fail;
    int cyc;
    int ack_delay;
    bit ack_force;
    bit dst_toggle;
    int stall_cnt;
    int hold_viol;
    int req_cycles;

    soc_it_message_recv_arbiter u_dut (
        .clk              (clk),
        .rst              (rst),
        .ch_valid         (ch_valid),
        .ch_ready         (ch_ready),
        .ch_last          (ch_last),
        .ch_data          (ch_data),
        .recv_msg_request (recv_msg_request),
        .recv_msg_ack     (recv_msg_ack),
        .recv_msg_src_rdy (recv_msg_src_rdy),
        .recv_msg_dst_rdy (recv_msg_dst_rdy),
        .recv_msg_payload (recv_msg_payload),
        .recv_msg_last    (recv_msg_last),
        .recv_msg_chan    (recv_msg_chan),
        .err_oversize     (err_oversize)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Downstream model: acks after ack_delay request cycles, optional dst_rdy toggling.
    initial begin
        int  age;
        bit  phase;
        age = 0;
        phase = 0;
        recv_msg_ack = 1'b0;
        recv_msg_dst_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (recv_msg_request) begin
                recv_msg_ack = ack_force || (age == ack_delay);
                age++;
                phase = 0;
                recv_msg_dst_rdy = 1'b1;
            end else begin
                recv_msg_ack = ack_force;
                age = 0;
                if (dst_toggle) begin
                    recv_msg_dst_rdy = !phase;
                    phase = !phase;
                end else begin
                    recv_msg_dst_rdy = 1'b1;
                end
            end
        end
    end

    // Monitor: captures accepted beats, stalls, and payload hold violations.
    initial begin
        bit            prev_stall;
        logic [DW-1:0] prev_pl;
        beat_t         b;
        prev_stall = 0;
        prev_pl = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (recv_msg_request) req_cycles++;
                if (prev_stall && (!recv_msg_src_rdy || recv_msg_payload !== prev_pl))
                    hold_viol++;
                if (recv_msg_src_rdy) begin
                    if (recv_msg_dst_rdy) begin
                        b.d = recv_msg_payload;
                        b.l = recv_msg_last;
                        b.c = recv_msg_chan;
                        b.cyc = cyc;
                        rx_q.push_back(b);
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            prev_stall = rst && recv_msg_src_rdy && !recv_msg_dst_rdy;
            prev_pl = recv_msg_payload;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic push_beat(input int ch, input logic [DW-1:0] d, input logic l);
        beat_t e;
        ch_valid[ch] = 1'b1;
        ch_last[ch] = l;
        ch_data[ch*DW +: DW] = d;
        e.d = d;
        e.l = l;
        e.c = 2'(ch);
        e.cyc = 0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        ch_valid[ch] = 1'b0;
        ch_last[ch] = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (rx_q.size() >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        rx_q.delete();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ch_valid = '0;
        ch_last = '0;
        ch_data = '0;
        ack_delay = 2;
        ack_force = 0;
        dst_toggle = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (recv_msg_request !== 1'b0 || recv_msg_src_rdy !== 1'b0 ||
            recv_msg_payload !== '0 || recv_msg_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b src=%b pl=%h last=%b want 0,0,0,0",
                     recv_msg_request, recv_msg_src_rdy, recv_msg_payload, recv_msg_last);
        end
        n_cmp++;
        if (ch_ready !== 4'h0 || err_oversize !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_ready: got ready=%h err=%h want 0,0", ch_ready, err_oversize);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ch_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL release_ready: got %h want f", ch_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit    ok;
        beat_t b;
        beat_t e;
        int    cy[$];
        push_beat(2, 128'hA, 1'b0);
        push_beat(2, 128'hB, 1'b0);
        push_beat(2, 128'hC, 1'b1);
        wait_rx(3, 50, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_timeout: got %0d beats want 3", rx_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL basic_beat: got none want d=%h", e.d);
            end else begin
                b = rx_q.pop_front();
                cy.push_back(b.cyc);
                if (b.d !== e.d || b.l !== e.l || b.c !== e.c) begin
                    n_fail++;
                    $display("FAIL basic_beat: got d=%h l=%b c=%0d want d=%h l=%b c=%0d",
                             b.d, b.l, b.c, e.d, e.l, e.c);
                end
            end
        end
        n_cmp++;
        if (cy.size() != 3 || cy[1] != cy[0] + 1 || cy[2] != cy[1] + 1) begin
            n_fail++;
            $display("FAIL basic_rate: got %0d beats non-consecutive want 3 consecutive", cy.size());
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (rx_q.size() != 0 || recv_msg_request !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_extra: got extra=%0d req=%b want 0,0", rx_q.size(), recv_msg_request);
        end
    endtask

    task automatic test_backpressure();
        bit    ok;
        beat_t b;
        beat_t e;
        stall_cnt = 0;
        hold_viol = 0;
        dst_toggle = 1;
        for (int k = 0; k < 4; k++)
            push_beat(1, DW'(32'h10 + k), k == 3);
        wait_rx(4, 80, ok);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok || rx_q.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats want 4", rx_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front();
            b = rx_q.pop_front();
            n_cmp++;
            if (b.d !== e.d || b.l !== e.l || b.c !== e.c) begin
                n_fail++;
                $display("FAIL bp_beat: got d=%h l=%b c=%0d want d=%h l=%b c=%0d",
                         b.d, b.l, b.c, e.d, e.l, e.c);
            end
        end
        n_cmp++;
        if (stall_cnt != 3 || hold_viol != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got stalls=%0d viol=%0d want 3,0", stall_cnt, hold_viol);
        end
        exp_q.delete();
        rx_q.delete();
        dst_toggle = 0;
    endtask

    task automatic test_round_robin();
        bit    ok;
        beat_t b;
        beat_t e;
        int    order[$];
        apply_reset();
        order = '{0, 1, 3, 0, 3, 0};
        ch_valid = 4'b1011;
        ch_last = 4'b1011;
        for (int i = 0; i < NCH; i++)
            ch_data[i*DW +: DW] = DW'(32'h200 + i);
        @(posedge clk);
        #1;
        ch_valid = '0;
        ch_last = '0;
        for (int k = 0; k < 3; k++) begin
            e.d = DW'(32'h200 + order[k]);
            e.l = 1'b1;
            e.c = 2'(order[k]);
            exp_q.push_back(e);
        end
        wait_rx(3, 100, ok);
        push_beat(0, DW'(32'h300), 1'b1);
        wait_rx(4, 60, ok);
        ch_valid = 4'b1001;
        ch_last = 4'b1001;
        ch_data[0 +: DW] = DW'(32'h310);
        ch_data[3*DW +: DW] = DW'(32'h313);
        @(posedge clk);
        #1;
        ch_valid = '0;
        ch_last = '0;
        e.d = DW'(32'h313);
        e.c = 2'd3;
        exp_q.push_back(e);
        e.d = DW'(32'h310);
        e.c = 2'd0;
        exp_q.push_back(e);
        wait_rx(6, 100, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d beats want 6", rx_q.size());
        end
        for (int k = 0; k < 6; k++) begin
            if (exp_q.size() == 0 || rx_q.size() == 0) break;
            e = exp_q.pop_front();
            b = rx_q.pop_front();
            n_cmp++;
            if (b.d !== e.d || b.c !== e.c || b.l !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_order%0d: got c=%0d d=%h want c=%0d d=%h",
                         k, b.c, b.d, e.c, e.d);
            end
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_ack_idle();
        bit    ok;
        beat_t b;
        ack_force = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (recv_msg_request !== 1'b0 || recv_msg_src_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL ack_idle%0d: got req=%b src=%b want 0,0",
                         k, recv_msg_request, recv_msg_src_rdy);
            end
        end
        @(posedge clk);
        #1;
        ack_force = 0;
        ack_delay = 3;
        req_cycles = 0;
        push_beat(2, DW'(32'h400), 1'b1);
        wait_rx(1, 60, ok);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok || rx_q.size() != 1) begin
            n_fail++;
            $display("FAIL ack_msg_count: got %0d want 1", rx_q.size());
        end else begin
            b = rx_q.pop_front();
            if (b.d !== DW'(32'h400) || b.c !== 2'd2) begin
                n_fail++;
                $display("FAIL ack_msg: got d=%h c=%0d want d=400 c=2", b.d, b.c);
            end
        end
        n_cmp++;
        if (req_cycles != 4) begin
            n_fail++;
            $display("FAIL ack_req_len: got %0d want 4", req_cycles);
        end
        exp_q.delete();
        rx_q.delete();
        ack_delay = 2;
    endtask

    task automatic test_oversize();
        bit    ok;
        int    not_ready;
        beat_t b;
        not_ready = 0;
        ch_valid[1] = 1'b1;
        ch_last[1] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ch_data[DW +: DW] = DW'(32'h500 + k);
            @(negedge clk);
            if (!ch_ready[1]) not_ready++;
            if (k == 15) begin
                n_cmp++;
                if (err_oversize !== 4'h0) begin
                    n_fail++;
                    $display("FAIL ovs_early: got err=%h want 0", err_oversize);
                end
            end
            @(posedge clk);
            #1;
        end
        ch_valid[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (not_ready != 0 || ch_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovs_ready: got blocked=%0d ready1=%b want 0,0", not_ready, ch_ready[1]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (err_oversize !== 4'b0010) begin
            n_fail++;
            $display("FAIL ovs_err: got %b want 0010", err_oversize);
        end
        @(posedge clk);
        #1;
        push_beat(0, DW'(32'h600), 1'b1);
        wait_rx(1, 60, ok);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok || rx_q.size() != 1) begin
            n_fail++;
            $display("FAIL ovs_other_count: got %0d want 1", rx_q.size());
        end else begin
            b = rx_q.pop_front();
            if (b.d !== DW'(32'h600) || b.c !== 2'd0) begin
                n_fail++;
                $display("FAIL ovs_other: got d=%h c=%0d want d=600 c=0", b.d, b.c);
            end
        end
        n_cmp++;
        if (err_oversize !== 4'b0010 || ch_ready[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovs_sticky: got err=%b ready1=%b want 0010,0", err_oversize, ch_ready[1]);
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_reset_mid();
        bit    ok;
        beat_t b;
        apply_reset();
        ack_delay = 1;
        for (int k = 0; k < 5; k++)
            push_beat(0, DW'(32'h700 + k), k == 4);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (recv_msg_src_rdy && recv_msg_payload === DW'(32'h700)) begin
                ok = 1;
                break;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rmid_start: got no beat1 want beat1 presented");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (recv_msg_src_rdy !== 1'b0 || recv_msg_payload !== '0 || recv_msg_last !== 1'b0 ||
            recv_msg_chan !== 2'd0 || recv_msg_request !== 1'b0 || ch_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got src=%b pl=%h last=%b chan=%0d req=%b rdy=%h want all 0",
                     recv_msg_src_rdy, recv_msg_payload, recv_msg_last, recv_msg_chan,
                     recv_msg_request, ch_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ch_ready !== 4'hF || err_oversize !== 4'h0 || recv_msg_src_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_release: got rdy=%h err=%h src=%b want f,0,0",
                     ch_ready, err_oversize, recv_msg_src_rdy);
        end
        repeat (20) @(posedge clk);
        #1;
        push_beat(0, DW'(32'h7AA), 1'b1);
        wait_rx(2, 60, ok);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (rx_q.size() != 2) begin
            n_fail++;
            $display("FAIL rmid_count: got %0d beats want 2", rx_q.size());
        end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            b = rx_q.pop_front();
            n_cmp++;
            if (b.d !== exp_q[0].d || b.l !== exp_q[0].l || b.c !== exp_q[0].c) begin
                n_fail++;
                $display("FAIL rmid_beat: got d=%h l=%b want d=%h l=%b",
                         b.d, b.l, exp_q[0].d, exp_q[0].l);
            end
            void'(exp_q.pop_front());
        end
        ack_delay = 2;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        stall_cnt = 0;
        hold_viol = 0;
        req_cycles = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_round_robin();
        test_ack_idle();
        test_oversize();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
